// File: rtl/regfile_issue_ctrl_if.sv
// Decode, register-file, writeback and execute signals of the issue controller.
// Signal suffixes are from the controller's point of view.
interface regfile_issue_ctrl_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
);
  logic                 dec_valid_i;
  logic                 dec_ready_o;
  logic [AddrWidth-1:0] dec_rs1_addr_i;
  logic                 dec_rs1_used_i;
  logic [AddrWidth-1:0] dec_rs2_addr_i;
  logic                 dec_rs2_used_i;
  logic [AddrWidth-1:0] dec_rd_addr_i;
  logic                 dec_rd_used_i;

  logic                 rf_rs1_valid_o;
  logic [AddrWidth-1:0] rf_rs1_addr_o;
  logic [DataWidth-1:0] rf_rs1_data_i;
  logic                 rf_rs2_valid_o;
  logic [AddrWidth-1:0] rf_rs2_addr_o;
  logic [DataWidth-1:0] rf_rs2_data_i;
  logic                 rf_wr_valid_o;
  logic [AddrWidth-1:0] rf_wr_addr_o;
  logic [DataWidth-1:0] rf_wr_data_o;

  logic                 wb_valid_i;
  logic [AddrWidth-1:0] wb_addr_i;
  logic [DataWidth-1:0] wb_data_i;

  logic                 ex_valid_o;
  logic                 ex_ready_i;
  logic [DataWidth-1:0] ex_rs1_data_o;
  logic [DataWidth-1:0] ex_rs2_data_o;
  logic [AddrWidth-1:0] ex_rd_addr_o;
  logic                 ex_rd_used_o;
  logic                 busy_o;

  modport slave (
    input  dec_valid_i, dec_rs1_addr_i, dec_rs1_used_i, dec_rs2_addr_i,
           dec_rs2_used_i, dec_rd_addr_i, dec_rd_used_i,
           rf_rs1_data_i, rf_rs2_data_i, wb_valid_i, wb_addr_i, wb_data_i,
           ex_ready_i,
    output dec_ready_o, rf_rs1_valid_o, rf_rs1_addr_o, rf_rs2_valid_o,
           rf_rs2_addr_o, rf_wr_valid_o, rf_wr_addr_o, rf_wr_data_o,
           ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o,
           ex_rd_used_o, busy_o
  );

  modport master (
    output dec_valid_i, dec_rs1_addr_i, dec_rs1_used_i, dec_rs2_addr_i,
           dec_rs2_used_i, dec_rd_addr_i, dec_rd_used_i,
           rf_rs1_data_i, rf_rs2_data_i, wb_valid_i, wb_addr_i, wb_data_i,
           ex_ready_i,
    input  dec_ready_o, rf_rs1_valid_o, rf_rs1_addr_o, rf_rs2_valid_o,
           rf_rs2_addr_o, rf_wr_valid_o, rf_wr_addr_o, rf_wr_data_o,
           ex_valid_o, ex_rs1_data_o, ex_rs2_data_o, ex_rd_addr_o,
           ex_rd_used_o, busy_o
  );
endinterface

// File: rtl/regfile_issue_ctrl.sv
// Operand fetch/issue controller: scoreboarded hazard check, 1-cycle RF read,
// writeback bypass and a skid hold stage toward execute.
module regfile_issue_ctrl #(
  parameter  int DataWidth  = 32,
  parameter  int NumEntries = 32,
  localparam int AddrWidth  = $clog2(NumEntries)
) (
  input logic               clk_i,
  input logic               reset_i,
  regfile_issue_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RESP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NumEntries-1:0] pending_q, pending_d;
  logic [NumEntries-1:0] wb_clr;
  logic [NumEntries-1:0] live_pending;
  logic                  rs1_live_q, rs1_live_d, rs2_live_q, rs2_live_d;
  logic                  byp1_q, byp1_d, byp2_q, byp2_d;
  logic [DataWidth-1:0]  byp_data_q, byp_data_d;
  logic [AddrWidth-1:0]  rd_addr_q, rd_addr_d;
  logic                  rd_used_q, rd_used_d;
  logic [DataWidth-1:0]  hold1_q, hold1_d, hold2_q, hold2_d;
  logic [DataWidth-1:0]  resp1, resp2;
  logic                  hazard, accept;

  // A writeback landing this cycle already resolves the hazard on its register.
  for (genvar gi = 0; gi < NumEntries; gi++) begin : g_wb_clr
    assign wb_clr[gi] = bus.wb_valid_i && (bus.wb_addr_i == AddrWidth'(gi));
  end
  assign live_pending = pending_q & ~wb_clr;

  assign hazard = (bus.dec_rs1_used_i && live_pending[bus.dec_rs1_addr_i]) ||
                  (bus.dec_rs2_used_i && live_pending[bus.dec_rs2_addr_i]) ||
                  (bus.dec_rd_used_i  && live_pending[bus.dec_rd_addr_i]);
  assign accept = !reset_i && (state_q == IDLE) && bus.dec_valid_i && !hazard;

  assign bus.dec_ready_o    = !reset_i && (state_q == IDLE) && !hazard;
  assign bus.rf_rs1_valid_o = accept && bus.dec_rs1_used_i;
  assign bus.rf_rs1_addr_o  = bus.dec_rs1_addr_i;
  assign bus.rf_rs2_valid_o = accept && bus.dec_rs2_used_i;
  assign bus.rf_rs2_addr_o  = bus.dec_rs2_addr_i;
  assign bus.rf_wr_valid_o  = !reset_i && bus.wb_valid_i && (bus.wb_addr_i != '0);
  assign bus.rf_wr_addr_o   = bus.wb_addr_i;
  assign bus.rf_wr_data_o   = bus.wb_data_i;

  assign resp1 = !rs1_live_q ? '0 : (byp1_q ? byp_data_q : bus.rf_rs1_data_i);
  assign resp2 = !rs2_live_q ? '0 : (byp2_q ? byp_data_q : bus.rf_rs2_data_i);

  assign bus.ex_valid_o    = !reset_i && (state_q != IDLE);
  assign bus.ex_rs1_data_o = (state_q == HOLD) ? hold1_q : resp1;
  assign bus.ex_rs2_data_o = (state_q == HOLD) ? hold2_q : resp2;
  assign bus.ex_rd_addr_o  = rd_addr_q;
  assign bus.ex_rd_used_o  = rd_used_q;
  assign bus.busy_o        = |pending_q;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q & ~wb_clr;
    rs1_live_d = rs1_live_q;
    rs2_live_d = rs2_live_q;
    byp1_d     = byp1_q;
    byp2_d     = byp2_q;
    byp_data_d = byp_data_q;
    rd_addr_d  = rd_addr_q;
    rd_used_d  = rd_used_q;
    hold1_d    = hold1_q;
    hold2_d    = hold2_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Setting after the writeback clear lets a new claim win at the same index.
          if (bus.dec_rd_used_i && (bus.dec_rd_addr_i != '0))
            pending_d[bus.dec_rd_addr_i] = 1'b1;
          rs1_live_d = bus.dec_rs1_used_i && (bus.dec_rs1_addr_i != '0);
          rs2_live_d = bus.dec_rs2_used_i && (bus.dec_rs2_addr_i != '0);
          byp1_d     = bus.wb_valid_i && (bus.wb_addr_i == bus.dec_rs1_addr_i) &&
                       (bus.dec_rs1_addr_i != '0);
          byp2_d     = bus.wb_valid_i && (bus.wb_addr_i == bus.dec_rs2_addr_i) &&
                       (bus.dec_rs2_addr_i != '0);
          byp_data_d = bus.wb_data_i;
          rd_addr_d  = bus.dec_rd_addr_i;
          rd_used_d  = bus.dec_rd_used_i;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.ex_ready_i) begin
          state_d = IDLE;
        end else begin
          hold1_d = resp1;
          hold2_d = resp2;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.ex_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      rs1_live_q <= 1'b0;
      rs2_live_q <= 1'b0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
      rd_addr_q  <= '0;
      rd_used_q  <= 1'b0;
      hold1_q    <= '0;
      hold2_q    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rs1_live_q <= rs1_live_d;
      rs2_live_q <= rs2_live_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      byp_data_q <= byp_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_used_q  <= rd_used_d;
      hold1_q    <= hold1_d;
      hold2_q    <= hold2_d;
    end
  end
endmodule
